rv_instr_stream_encoder: RTL and testbench



---
 rtl/rv_isa_defs.sv | 32 +++
 rtl/rv_field_packer.sv | 43 ++++
 rtl/rv_instr_stream_encoder.sv | 128 ++++++++++++
 tb/tb_rv_instr_stream_encoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_defs.sv
// Shared RV32I definitions: opcodes, request kind codes and encoder FSM states.
// Imported by the instruction-stream encoder and the main control decoder.
package rv_isa_defs;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

  typedef enum logic [2:0] {
    KIND_R       = 3'd0,
    KIND_I       = 3'd1,
    KIND_LOAD    = 3'd2,
    KIND_STORE   = 3'd3,
    KIND_BRANCH  = 3'd4,
    KIND_JAL     = 3'd5,
    KIND_LUI     = 3'd6,
    KIND_ILLEGAL = 3'd7
  } req_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } enc_state_e;

endpackage

// File: rtl/rv_field_packer.sv
// Combinational packer: turns a field-level request into a 32-bit RV32I word.
// legal is low only for the reserved kind code; unused fields are ignored.
module rv_field_packer
  import rv_isa_defs::*;
(
  input  logic [2:0]  kind,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Field placement per instruction format
  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (req_kind_e'(kind))
      KIND_R:      word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OPC_R};
      KIND_I: begin
        // Immediate shifts carry the arithmetic/logical select in bit 30
        if (funct3 == F3_SHIFT_RIGHT) begin
          word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OPC_I};
        end else begin
          word = {imm[11:0], rs1, funct3, rd, OPC_I};
        end
      end
      KIND_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      KIND_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      KIND_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      KIND_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      KIND_LUI:    word = {imm[31:12], rd, OPC_LUI};
      default: begin
        word  = 32'h0000_0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv_instr_stream_encoder.sv
// Sequential RV32I encoder/loader: accepts field requests, writes packed words
// to consecutive instruction-memory addresses, flags illegal kinds and overflow.
module rv_instr_stream_encoder
  import rv_isa_defs::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  input  logic              req_last,
  output logic              imem_wr_valid,
  input  logic              imem_wr_ready,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              done,
  output logic              err,
  output logic              full
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  enc_state_e        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       data_r;
  logic              last_r;
  logic              valid_r;
  logic              ready_r;
  logic              done_r;
  logic              err_r;
  logic              full_r;
  logic [31:0]       word_s;
  logic              legal_s;

  rv_field_packer u_packer (
    .kind     (req_kind),
    .funct3   (req_funct3),
    .funct7b5 (req_funct7b5),
    .rd       (req_rd),
    .rs1      (req_rs1),
    .rs2      (req_rs2),
    .imm      (req_imm),
    .word     (word_s),
    .legal    (legal_s)
  );

  // Control FSM, address counter and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      addr_r  <= BASE_ADDR;
      data_r  <= 32'h0000_0000;
      last_r  <= 1'b0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      full_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (req_valid && ready_r) begin
            // Rejected requests are consumed without a write
            if (legal_s && !full_r) begin
              data_r  <= word_s;
              last_r  <= req_last;
              valid_r <= 1'b1;
              ready_r <= 1'b0;
              state_r <= ST_WRITE;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (imem_wr_ready) begin
            valid_r <= 1'b0;
            // The top address is never wrapped; it saturates and raises full
            if (addr_r == ADDR_MAX) begin
              full_r <= 1'b1;
            end else begin
              addr_r <= addr_r + ADDR_W'(1);
            end
            if (last_r) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              ready_r <= 1'b1;
              state_r <= ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          addr_r  <= BASE_ADDR;
          full_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = ready_r;
  assign imem_wr_valid = valid_r;
  assign imem_wr_addr  = addr_r;
  assign imem_wr_data  = data_r;
  assign done          = done_r;
  assign err           = err_r;
  assign full          = full_r;

endmodule

// File: tb/tb_rv_instr_stream_encoder.sv
// Directed bench for rv_instr_stream_encoder: hand-computed RV32I words,
// stall, illegal/last handling, reset mid-write and address overflow.
module tb_rv_instr_stream_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [2:0]  req_funct3;
  logic        req_funct7b5;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        req_last;
  logic        imem_wr_valid;
  logic        imem_wr_ready;
  logic [7:0]  imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        done;
  logic        err;
  logic        full;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0]  kind;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  rv_instr_stream_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_kind      (req_kind),
    .req_funct3    (req_funct3),
    .req_funct7b5  (req_funct7b5),
    .req_rd        (req_rd),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_imm       (req_imm),
    .req_last      (req_last),
    .imem_wr_valid (imem_wr_valid),
    .imem_wr_ready (imem_wr_ready),
    .imem_wr_addr  (imem_wr_addr),
    .imem_wr_data  (imem_wr_data),
    .done          (done),
    .err           (err),
    .full          (full)
  );

  // Presents one request for a single cycle, then scrambles the fields.
  // Called and returns at 1 time unit after a rising edge.
  task automatic drive_req(input logic [2:0] kind, input logic [2:0] f3, input logic f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic last);
    req_kind     = kind;
    req_funct3   = f3;
    req_funct7b5 = f7;
    req_rd       = rd;
    req_rs1      = rs1;
    req_rs2      = rs2;
    req_imm      = imm;
    req_last     = last;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_kind     = 3'd7;
    req_funct3   = 3'd7;
    req_rd       = 5'd31;
    req_rs1      = 5'd31;
    req_rs2      = 5'd31;
    req_imm      = 32'hDEAD_BEEF;
    req_last     = 1'b1;
  endtask

  task automatic test_reset();
    logic [44:0] act;
    act = {req_ready, imem_wr_valid, imem_wr_addr, imem_wr_data, done, err, full};
    n_vec++;
    if (act !== {1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: got %h expected %h", act,
               {1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_single_words();
    logic [41:0] act;
    logic [41:0] exp;
    vecs[0] = '{3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3};
    vecs[1] = '{3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3};
    vecs[2] = '{3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF,   32'hFFF00293};
    vecs[3] = '{3'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423};
    vecs[4] = '{3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE208EE3};
    vecs[5] = '{3'd5, 3'd0, 1'b0, 5'd1, 5'd7, 5'd9, 32'd9,          32'h008000EF};
    vecs[6] = '{3'd6, 3'd0, 1'b0, 5'd5, 5'd3, 5'd4, 32'h12345ABC,   32'h123452B7};
    vecs[7] = '{3'd1, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3,          32'h4030D093};
    for (int i = 0; i < 8; i++) begin
      drive_req(vecs[i].kind, vecs[i].f3, vecs[i].f7, vecs[i].rd, vecs[i].rs1,
                vecs[i].rs2, vecs[i].imm, 1'b0);
      act = {imem_wr_valid, req_ready, imem_wr_addr, imem_wr_data};
      exp = {1'b1, 1'b0, 8'(i), vecs[i].exp};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL single_write[%0d]: got %h expected %h", i, act, exp);
      end
      @(posedge clk); #1;
      act = {imem_wr_valid, req_ready, imem_wr_addr, 32'h0};
      exp = {1'b0, 1'b1, 8'(i + 1), 32'h0};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL single_complete[%0d]: got %h expected %h", i, act, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [41:0] act;
    imem_wr_ready = 1'b0;
    drive_req(3'd2, 3'd2, 1'b0, 5'd4, 5'd2, 5'd0, 32'd12, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      act = {imem_wr_valid, req_ready, imem_wr_addr, imem_wr_data};
      n_vec++;
      if (act !== {1'b1, 1'b0, 8'd8, 32'h00C12203}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", c, act,
                 {1'b1, 1'b0, 8'd8, 32'h00C12203});
      end
    end
    imem_wr_ready = 1'b1;
    @(posedge clk); #1;
    act = {imem_wr_valid, req_ready, imem_wr_addr, 32'h0};
    n_vec++;
    if (act !== {1'b0, 1'b1, 8'd9, 32'h0}) begin
      n_err++;
      $display("FAIL stall_release: got %h expected %h", act, {1'b0, 1'b1, 8'd9, 32'h0});
    end
  endtask

  task automatic test_illegal_last();
    logic [11:0] act;
    drive_req(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    act = {imem_wr_valid, err, req_ready, done, imem_wr_addr};
    n_vec++;
    if (act !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd9}) begin
      n_err++;
      $display("FAIL illegal_reject: got %h expected %h", act, {1'b0, 1'b1, 1'b1, 1'b0, 8'd9});
    end
    @(posedge clk); #1;
    n_vec++;
    if (imem_wr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_no_write: got %b expected 0", imem_wr_valid);
    end
    drive_req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    act = {imem_wr_valid, err, req_ready, done, imem_wr_addr};
    n_vec++;
    if (act !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd9}) begin
      n_err++;
      $display("FAIL last_write: got %h expected %h", act, {1'b1, 1'b1, 1'b0, 1'b0, 8'd9});
    end
    @(posedge clk); #1;
    act = {imem_wr_valid, err, req_ready, done, 8'h00};
    n_vec++;
    if (act !== {1'b0, 1'b1, 1'b0, 1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL done_pulse: got %h expected %h", act, {1'b0, 1'b1, 1'b0, 1'b1, 8'h00});
    end
    @(posedge clk); #1;
    act = {imem_wr_valid, err, req_ready, done, imem_wr_addr};
    n_vec++;
    if (act !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL done_end: got %h expected %h", act, {1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
    end
    drive_req(3'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0);
    act = {imem_wr_valid, err, req_ready, done, imem_wr_addr};
    n_vec++;
    if (act !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL restart_addr: got %h expected %h", act, {1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    logic [44:0] act;
    imem_wr_ready = 1'b0;
    drive_req(3'd2, 3'd2, 1'b0, 5'd4, 5'd2, 5'd0, 32'd12, 1'b0);
    @(posedge clk); #1;
    n_vec++;
    if (imem_wr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_write_pending: got %b expected 1", imem_wr_valid);
    end
    rst_n = 1'b0;
    #1;
    act = {req_ready, imem_wr_valid, imem_wr_addr, imem_wr_data, done, err, full};
    n_vec++;
    if (act !== {1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", act,
               {1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_wr_ready = 1'b1;
    @(posedge clk); #1;
    act = {req_ready, imem_wr_valid, imem_wr_addr, imem_wr_data, done, err, full};
    n_vec++;
    if (act !== {1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL post_reset: got %h expected %h", act,
               {1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0});
    end
    drive_req(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    act = {req_ready, imem_wr_valid, imem_wr_addr, imem_wr_data, done, err, full};
    n_vec++;
    if (act !== {1'b0, 1'b1, 8'h00, 32'h402081B3, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL post_reset_write: got %h expected %h", act,
               {1'b0, 1'b1, 8'h00, 32'h402081B3, 1'b0, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic [10:0] act;
    logic [10:0] exp;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive_req(3'd1, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'(i), 1'b0);
      act = {imem_wr_valid, full, err, imem_wr_addr};
      exp = {1'b1, 1'b0, 1'b0, 8'(i)};
      @(posedge clk); #1;
      act = (act == exp) ? {imem_wr_valid, full, err, imem_wr_addr} : act;
      exp = (act[10] == 1'b1) ? exp : {1'b0, (i == 255), 1'b0, (i == 255) ? 8'hFF : 8'(i + 1)};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL overflow_fill[%0d]: got %h expected %h", i, act, exp);
      end
    end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_ready: got %b expected 1", req_ready);
    end
    drive_req(3'd1, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0);
    act = {imem_wr_valid, full, err, imem_wr_addr};
    n_vec++;
    if (act !== {1'b0, 1'b1, 1'b1, 8'hFF}) begin
      n_err++;
      $display("FAIL overflow_reject: got %h expected %h", act, {1'b0, 1'b1, 1'b1, 8'hFF});
    end
    @(posedge clk); #1;
    act = {imem_wr_valid, full, err, imem_wr_addr};
    n_vec++;
    if (act !== {1'b0, 1'b1, 1'b1, 8'hFF}) begin
      n_err++;
      $display("FAIL overflow_hold: got %h expected %h", act, {1'b0, 1'b1, 1'b1, 8'hFF});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec %0d", n_vec);
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_kind      = 3'd0;
    req_funct3    = 3'd0;
    req_funct7b5  = 1'b0;
    req_rd        = 5'd0;
    req_rs1       = 5'd0;
    req_rs2       = 5'd0;
    req_imm       = 32'h0;
    req_last      = 1'b0;
    imem_wr_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single_words();
    test_stall();
    test_illegal_last();
    test_reset_mid_write();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
